neighbor_table_writer: RTL
==========================

// Module: neighbor_table_writer
// PURPOSE
//  Writer side of the node's neighbor table in shared word memory. Takes one received neighbor
//  report (ID, hop count, Q value) per handshake. Searches the table; an existing entry's hops/Q
//  are overwritten, otherwise the entry is appended and neighborCount incremented. Table layout is
//  the one the best-neighbor selection logic reads back.
// PARAMETERS
//  MAX_NEIGHBORS  32      table capacity in entries (hops/Q regions hold 32 words each)
//  ADDR_NCOUNT    11'h2C4 byte address of neighborCount word
//  ADDR_NID       11'h72  base byte address of neighborID[] (entry n at base+2n)
//  ADDR_NHOPS     11'h132 base byte address of neighborHops[]
//  ADDR_NQ        11'h172 base byte address of neighborQValue[]
// PORTS
//  clock      in   1   single clock, all logic on posedge
//  rst        in   1   synchronous active-high reset
//  en         in   1   block enable; gates ready
//  upd_valid  in   1   report valid; accepted when upd_valid & ready
//  rx_nID     in   16  reported neighbor ID
//  rx_hops    in   16  reported hop count
//  rx_Q       in   16  reported Q value
//  ready      out  1   = en & (state==S_IDLE)
//  done       out  1   one-cycle pulse when report fully processed
//  status     out  2   01 updated, 10 appended, 11 dropped (table full); held until next accept
//  address    out  11  byte address to memory (word-aligned, step 2)
//  data_in    in   16  memory read data; valid the cycle after address is loaded
//  data_out   out  16  memory write data
//  wr_en      out  1   write strobe; memory writes data_out at address on that edge
// BEHAVIOUR
//  - Reset: state=S_IDLE, address=0, data_out=0, wr_en=0, done=0, status=0, latched fields=0.
//    Reset mid-operation aborts at that edge; wr_en low next cycle. neighborCount is written last,
//    so an aborted append leaves the count unchanged (partial entry invisible to readers).
//  - T0 = accept cycle. Report latched; address<=ADDR_NCOUNT; -> S_RDCNT.
//  - S_RDCNT (T1): cnt<=data_in clamped to MAX_NEIGHBORS; i=0; cnt==0 -> S_APPEND else address<=ADDR_NID.
//  - S_SCAN: data_in==rx_nID (full 16b) -> S_WRH at index i; else i++; i==cnt -> S_APPEND,
//    else address<=ADDR_NID+2i. One entry per cycle.
//  - S_APPEND: cnt==MAX_NEIGHBORS -> status=11, no writes, S_DONE. Else write rx_nID @ADDR_NID+2cnt.
//  - S_WRH: write rx_hops @ADDR_NHOPS+2k; S_WRQ: write rx_Q @ADDR_NQ+2k (k=i update, k=cnt append).
//  - S_WRCNT (append only): write cnt+1 @ADDR_NCOUNT.
//  - S_DONE: done=1 one cycle, wr_en=0 -> S_IDLE. Every write is a single-cycle wr_en pulse, in order
//    ID, hops, Q, count; all 16-bit writes, index math in 11 bits (2*i never exceeds 2*MAX_NEIGHBORS).
//  - Latency to done: update at index i: T0+5+i; append with count c: T0+6+c; drop: T0+3+MAX_NEIGHBORS.
//  - upd_valid while busy or en=0: not accepted, upstream holds. en deassert mid-operation: ignored,
//    operation completes. Duplicate ID appearing twice in memory: first match (lowest i) updated.
// CONFIGURATION
//  NT_KEEP_MIN_HOPS_EN defined: on the update path, match in S_SCAN loads address<=ADDR_NHOPS+2i,
//    extra state S_RDH latches stored hops; S_WRH writes min(stored, rx_hops) (unsigned). Update
//    latency becomes T0+6+i. Append path unchanged.
//  Not defined: S_RDH absent; rx_hops always overwrites.
// TESTING
//  1 rst high 2 cycles, en=1 -> wr_en=0, done=0, status=00, address=0, ready=1.
//  2 count=0; report {ID=5,H=2,Q=0x0100} -> writes 0x72=5, 0x132=2, 0x172=0x0100, 0x2C4=1;
//    status=10; done at T0+6.
//  3 count=3, IDs {4,5,9}; report {ID=5,H=3,Q=0x0200} -> writes 0x134=3, 0x174=0x0200 only,
//    no count write; status=01; done at T0+6 (T0+7 with NT_KEEP_MIN_HOPS_EN).
//  4 count=32, report ID=0x40 -> no wr_en pulses; status=11; done at T0+35.
//  5 count=3, append ID=7; rst asserted the cycle after ID write -> 0x2C4 stays 3; wr_en=0 next
//    cycle; ready=1 after reset.
//  6 NT_KEEP_MIN_HOPS_EN: entry ID=9 stored hops 2, report {ID=9,H=5} -> hops write data 2;
//    report {ID=9,H=1} -> hops write data 1.

Source files
------------

// File: rtl/neighbor_table_writer.sv
// neighbor_table_writer: applies one neighbor report to the shared-memory neighbor table (update or append).
// Latency: update T0+5+i, append T0+6+count, drop T0+3+MAX_NEIGHBORS (update +1 with NT_KEEP_MIN_HOPS_EN).
// Backpressure: ready only when idle and en high; upstream holds the report during a table walk.
// Optional: define NT_KEEP_MIN_HOPS_EN to keep the smaller of stored and reported hops on update.
module neighbor_table_writer #(
   parameter int          MAX_NEIGHBORS = 32,
   parameter logic [10:0] ADDR_NCOUNT   = 11'h2C4,
   parameter logic [10:0] ADDR_NID      = 11'h072,
   parameter logic [10:0] ADDR_NHOPS    = 11'h132,
   parameter logic [10:0] ADDR_NQ       = 11'h172
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        en,
   input  logic        upd_valid,
   input  logic [15:0] rx_nID,
   input  logic [15:0] rx_hops,
   input  logic [15:0] rx_Q,
   output logic        ready,
   output logic        done,
   output logic [1:0]  status,
   output logic [10:0] address,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        wr_en
);
   localparam int            CW    = $clog2(MAX_NEIGHBORS + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_NEIGHBORS);
   localparam logic [15:0]   MAX_W = 16'(MAX_NEIGHBORS);

   typedef enum logic [3:0] {
      S_IDLE, S_RDCNT, S_SCAN, S_APPEND,
`ifdef NT_KEEP_MIN_HOPS_EN
      S_RDH,
`endif
      S_WRH, S_WRQ, S_WRCNT, S_DONE
   } state_t;

   state_t        state;
   logic [15:0]   nid_q, hops_q, q_q;
   logic [CW-1:0] cnt, idx, slot;
   logic          appending;
   logic [CW-1:0] cnt_rd, idx_nxt;

   // word address of entry n in a table region
   function automatic logic [10:0] slot_addr(input logic [10:0] base, input logic [CW-1:0] n);
      return base + 11'({n, 1'b0});
   endfunction

   // stored count is clamped so a corrupted count word can never walk past the table
   always_comb begin
      cnt_rd  = (data_in > MAX_W) ? MAX_C : data_in[CW-1:0];
      idx_nxt = idx + CW'(1);
      ready   = en && (state == S_IDLE);
   end

   // table walk: read count, scan IDs, then write ID/hops/Q/count; count goes last so aborts stay invisible
   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= S_IDLE;
         address   <= '0;
         data_out  <= '0;
         wr_en     <= 1'b0;
         done      <= 1'b0;
         status    <= 2'b00;
         nid_q     <= '0;
         hops_q    <= '0;
         q_q       <= '0;
         cnt       <= '0;
         idx       <= '0;
         slot      <= '0;
         appending <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (upd_valid && ready) begin
                  nid_q     <= rx_nID;
                  hops_q    <= rx_hops;
                  q_q       <= rx_Q;
                  status    <= 2'b00;
                  appending <= 1'b0;
                  address   <= ADDR_NCOUNT;
                  state     <= S_RDCNT;
               end
            end
            S_RDCNT: begin
               cnt <= cnt_rd;
               idx <= '0;
               if (cnt_rd == '0) begin
                  // empty table: go straight to appending entry 0
                  slot      <= '0;
                  appending <= 1'b1;
                  address   <= ADDR_NID;
                  data_out  <= nid_q;
                  wr_en     <= 1'b1;
                  state     <= S_APPEND;
               end else begin
                  address <= ADDR_NID;
                  state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (data_in == nid_q) begin
                  slot    <= idx;
                  address <= slot_addr(ADDR_NHOPS, idx);
`ifdef NT_KEEP_MIN_HOPS_EN
                  state   <= S_RDH;
`else
                  data_out <= hops_q;
                  wr_en    <= 1'b1;
                  state    <= S_WRH;
`endif
               end else if (idx_nxt == cnt) begin
                  // no match: append at the end unless the table is already full
                  slot      <= cnt;
                  appending <= 1'b1;
                  address   <= slot_addr(ADDR_NID, cnt);
                  data_out  <= nid_q;
                  wr_en     <= (cnt != MAX_C);
                  state     <= S_APPEND;
               end else begin
                  idx     <= idx_nxt;
                  address <= slot_addr(ADDR_NID, idx_nxt);
               end
            end
            S_APPEND: begin
               if (slot == MAX_C) begin
                  status <= 2'b11;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  address  <= slot_addr(ADDR_NHOPS, slot);
                  data_out <= hops_q;
                  wr_en    <= 1'b1;
                  state    <= S_WRH;
               end
            end
`ifdef NT_KEEP_MIN_HOPS_EN
            S_RDH: begin
               // address already points at the stored hops word
               data_out <= (data_in < hops_q) ? data_in : hops_q;
               wr_en    <= 1'b1;
               state    <= S_WRH;
            end
`endif
            S_WRH: begin
               address  <= slot_addr(ADDR_NQ, slot);
               data_out <= q_q;
               wr_en    <= 1'b1;
               state    <= S_WRQ;
            end
            S_WRQ: begin
               if (appending) begin
                  address  <= ADDR_NCOUNT;
                  data_out <= 16'(cnt) + 16'd1;
                  wr_en    <= 1'b1;
                  state    <= S_WRCNT;
               end else begin
                  status <= 2'b01;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_WRCNT: begin
               status <= 2'b10;
               done   <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
